debouncer_multi: RTL

Parametrised multi-channel successor to the single-button debouncer: NCH independent push-button/switch inputs, each synchronised, debounced over a programmable stable window, and reported as a clean level plus one-cycle press/release pulses. Sits between raw board I/O pins and the control logic. All channels run on the system clock; an optional long-press detector is compiled in per build.

---
 rtl/debounce_pkg.sv | 18 +
 rtl/debounce_channel.sv | 144 ++++++++++++++
 rtl/debouncer_multi.sv | 53 +++++
 3 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Items shared by the multi-channel debouncer:
//   - deb_state_e       : per-channel FSM state (IDLE, COUNT)
//   - DEF_STABLE_CYCLES : default stable window, 10 ms at the 5 MHz board clock
//   - DEF_LONG_CYCLES   : default long-press time, 1 s at the 5 MHz board clock
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } deb_state_e;

  localparam int DEF_STABLE_CYCLES = 50000;
  localparam int DEF_LONG_CYCLES   = 5000000;

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debounce lane: a 2-flop synchroniser, an IDLE/COUNT FSM with its stable
// window counter, registered press/release pulses and an optional long-press
// detector.
// Build option: DEBOUNCE_LONGPRESS_EN compiles in the long-press counter.
// Without it, long_hit is tied to 0.
//
// Ports:
//   sysclk   in  system clock, rising edge
//   rst      in  asynchronous active-high reset
//   din      in  raw level, already inverted to 1 = pressed
//   deb      out debounced level
//   rise     out one-cycle pulse when deb goes 0->1
//   fall     out one-cycle pulse when deb goes 1->0
//   long_hit out high from long-press detection until release
// -----------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
  input  logic sysclk,
  input  logic rst,
  input  logic din,
  output logic deb,
  output logic rise,
  output logic fall,
  output logic long_hit
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  // Reject parameter values the counters cannot represent.
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("debounce_channel: STABLE_CYCLES must be at least 2");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("debounce_channel: LONG_CYCLES must be at least 1");
  end

  logic          sync1;
  logic          s;
  deb_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          deb_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= din;
      s     <= sync1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    deb_nxt   = deb;
    case (state)
      IDLE: begin
        if (s != deb) begin
          state_nxt = COUNT;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      COUNT: begin
        if (s == deb) begin
          // Excursion ended early: drop it without touching the output.
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          // This is the STABLE_CYCLES-th consecutive differing sample.
          deb_nxt   = ~deb;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      deb   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      deb   <= deb_nxt;
      // Pulses are registered alongside deb so they share its edge.
      rise  <= deb_nxt & ~deb;
      fall  <= ~deb_nxt & deb;
    end
  end

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_PREV = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] long_cnt;
  logic          long_q;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      long_cnt <= '0;
      long_q   <= 1'b0;
    end else begin
      if (!deb) begin
        long_cnt <= '0;
      end else if (long_cnt != LONG_MAX) begin
        long_cnt <= long_cnt + LW'(1);
      end
      // Set on the edge the counter reaches LONG_CYCLES; a release on the
      // same edge wins so the flag drops together with deb.
      long_q <= deb_nxt & (long_q | (deb & (long_cnt == LONG_PREV)));
    end
  end

  assign long_hit = long_q;
`else
  assign long_hit = 1'b0;
`endif

endmodule

// File: rtl/debouncer_multi.sv
// -----------------------------------------------------------------------------
// debouncer_multi
// NCH independent push-button debouncers on one system clock. Raw pins are
// optionally inverted (ACTIVE_LOW) so that 1 always means pressed inside,
// then each is handled by its own debounce_channel.
// Build option: DEBOUNCE_LONGPRESS_EN enables btn_long; otherwise it is 0.
//
// Ports:
//   sysclk   in  system clock, rising edge
//   rst      in  asynchronous active-high reset
//   btn      in  [NCH] raw asynchronous button pins
//   btn_deb  out [NCH] debounced level, 1 = pressed
//   btn_rise out [NCH] one-cycle pulse on btn_deb 0->1
//   btn_fall out [NCH] one-cycle pulse on btn_deb 1->0
//   btn_long out [NCH] long press held (DEBOUNCE_LONGPRESS_EN only)
// -----------------------------------------------------------------------------
module debouncer_multi
  import debounce_pkg::*;
#(
  parameter int NCH           = 4,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int ACTIVE_LOW    = 0,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
  input  logic           sysclk,
  input  logic           rst,
  input  logic [NCH-1:0] btn,
  output logic [NCH-1:0] btn_deb,
  output logic [NCH-1:0] btn_rise,
  output logic [NCH-1:0] btn_fall,
  output logic [NCH-1:0] btn_long
);

  logic [NCH-1:0] btn_pol;

  assign btn_pol = (ACTIVE_LOW != 0) ? ~btn : btn;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES)
    ) u_ch (
      .sysclk  (sysclk),
      .rst     (rst),
      .din     (btn_pol[i]),
      .deb     (btn_deb[i]),
      .rise    (btn_rise[i]),
      .fall    (btn_fall[i]),
      .long_hit(btn_long[i])
    );
  end

endmodule
